// File: rtl/net_top.sv
// Purpose: packs streamed 16-bit audio samples into fixed-size UDP payloads; the first byte of each received packet switches streaming on or off.
// Latency: udp_send_data_valid rises one cycle after the wav_wren that fills the last sample slot.
// Backpressure: one holding register; a payload that completes while the previous one is unaccepted is dropped.
module net_top #(
    parameter int SAMPLES_PER_PKT = 60,
    parameter int PAYLOAD_BYTES   = 120
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [15:0]                 wav_in_data,
    input  logic                        wav_wren,
    output logic                        udp_send_data_valid,
    input  logic                        udp_send_data_ready,
    output logic [16*SAMPLES_PER_PKT:0] udp_send_data,
    output logic [15:0]                 udp_send_data_length,
    input  logic                        udp_rec_data_valid,
    input  logic [7:0]                  udp_rec_rdata,
    input  logic [15:0]                 udp_rec_data_length
);

    localparam int PW = 16 * SAMPLES_PER_PKT;
    localparam int CW = (SAMPLES_PER_PKT > 1) ? $clog2(SAMPLES_PER_PKT) : 1;
    localparam logic [CW-1:0] LAST_SLOT = CW'(SAMPLES_PER_PKT - 1);

    logic          stream_en;
    logic          rec_vld_q;
    logic [CW-1:0] cnt;
    logic [PW-1:0] fill;
    logic [PW-1:0] fill_nxt;
    logic [PW-1:0] hold;
    logic          seq;
    logic          send_vld;

    logic cmd_stb;
    logic cmd_off;
    logic cmd_on;
    logic take;
    logic pkt_done;
    logic accept;
    logic load;

    // Received length only describes the packet; commands are decoded from the first byte alone.
    logic unused_rec_len;
    assign unused_rec_len = ^udp_rec_data_length;

    // Command decode on the first byte of a received packet; a disable in the
    // same cycle as a strobe wins, so that sample never enters the new packet.
    always_comb begin
        cmd_stb  = udp_rec_data_valid & ~rec_vld_q;
        cmd_off  = cmd_stb & (udp_rec_rdata == 8'h00);
        cmd_on   = cmd_stb & (udp_rec_rdata == 8'h01);
        take     = wav_wren & stream_en & ~cmd_off;
        pkt_done = take & (cnt == LAST_SLOT);
        accept   = send_vld & udp_send_data_ready;
        load     = pkt_done & (~send_vld | udp_send_data_ready);
    end

    // Fill register with the current sample placed in its big-endian slot (slot 0 = MSBs).
    always_comb begin
        fill_nxt = fill;
        for (int k = 0; k < SAMPLES_PER_PKT; k++) begin
            if (take && (cnt == CW'(k))) begin
                fill_nxt[PW-1-16*k -: 16] = wav_in_data;
            end
        end
    end

    // Streaming enable and received-valid history for first-byte detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stream_en <= 1'b1;
            rec_vld_q <= 1'b0;
        end else begin
            rec_vld_q <= udp_rec_data_valid;
            if (cmd_off) begin
                stream_en <= 1'b0;
            end else if (cmd_on) begin
                stream_en <= 1'b1;
            end
        end
    end

    // Sample counter and fill register; disable throws away the partial packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            fill <= '0;
        end else if (cmd_off) begin
            cnt  <= '0;
            fill <= '0;
        end else if (take) begin
            fill <= fill_nxt;
            cnt  <= pkt_done ? '0 : cnt + 1'b1;
        end
    end

    // Output holding register: load when empty or being accepted this cycle, else drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold     <= '0;
            seq      <= 1'b0;
            send_vld <= 1'b0;
        end else if (load) begin
            hold     <= fill_nxt;
            seq      <= ~seq;
            send_vld <= 1'b1;
        end else if (accept) begin
            send_vld <= 1'b0;
        end
    end

    assign udp_send_data_valid  = send_vld;
    assign udp_send_data        = {seq, hold};
    assign udp_send_data_length = 16'(PAYLOAD_BYTES);

endmodule

// File: tb/tb_net_top.sv
module tb_net_top;

    localparam int N  = 60;
    localparam int PW = 16 * N;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   wav_in_data = '0;
    logic          wav_wren = 1'b0;
    logic          udp_send_data_valid;
    logic          udp_send_data_ready = 1'b0;
    logic [PW:0]   udp_send_data;
    logic [15:0]   udp_send_data_length;
    logic          udp_rec_data_valid = 1'b0;
    logic [7:0]    udp_rec_rdata = '0;
    logic [15:0]   udp_rec_data_length = 16'd0;

    net_top #(.SAMPLES_PER_PKT(N), .PAYLOAD_BYTES(2*N)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .wav_in_data         (wav_in_data),
        .wav_wren            (wav_wren),
        .udp_send_data_valid (udp_send_data_valid),
        .udp_send_data_ready (udp_send_data_ready),
        .udp_send_data       (udp_send_data),
        .udp_send_data_length(udp_send_data_length),
        .udp_rec_data_valid  (udp_rec_data_valid),
        .udp_rec_rdata       (udp_rec_rdata),
        .udp_rec_data_length (udp_rec_data_length)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // Reference model: list of samples gathered for the packet under construction,
    // plus the packet currently offered to the transmitter.
    bit            m_stream;
    bit            m_vld;
    bit            m_seq;
    bit            m_prev_rec;
    logic [PW-1:0] m_hold;
    logic [15:0]   m_cur[$];
    int            m_pkts;

    function automatic void model_reset();
        m_stream   = 1'b1;
        m_vld      = 1'b0;
        m_seq      = 1'b0;
        m_prev_rec = 1'b0;
        m_hold     = '0;
        m_cur.delete();
    endfunction

    function automatic void model_step(input bit wr, input logic [15:0] d, input bit rdy,
                                       input bit rv, input logic [7:0] rb);
        bit first_byte;
        bit was_taken;
        bit accepted;
        first_byte = rv && !m_prev_rec;
        accepted   = m_vld && rdy;
        was_taken  = 1'b0;
        m_prev_rec = rv;
        if (first_byte && rb == 8'h00) begin
            m_stream = 1'b0;
            m_cur.delete();
        end else begin
            if (m_stream && wr) begin
                m_cur.push_back(d);
                if (m_cur.size() == N) begin
                    if (!m_vld || accepted) begin
                        for (int k = 0; k < N; k++) m_hold[PW-1-16*k -: 16] = m_cur[k];
                        m_seq = !m_seq;
                        m_vld = 1'b1;
                        m_pkts++;
                        was_taken = 1'b1;
                    end
                    m_cur.delete();
                end
            end
            if (first_byte && rb == 8'h01) m_stream = 1'b1;
        end
        if (accepted && !was_taken) m_vld = 1'b0;
    endfunction

    task automatic compare_outputs();
        check("valid", 64'(udp_send_data_valid), 64'(m_vld));
        check("seqbit", 64'(udp_send_data[PW]), 64'(m_seq));
        if (m_vld) begin
            for (int c = 0; c < PW / 64; c++) begin
                check($sformatf("payload[%0d]", c), udp_send_data[64*c +: 64], m_hold[64*c +: 64]);
            end
        end
    endtask

    // One clock cycle: drive at negedge, model the edge, sample 1 time unit after posedge.
    task automatic cyc(input bit wr, input logic [15:0] d, input bit rdy,
                       input bit rv, input logic [7:0] rb);
        wav_wren            = wr;
        wav_in_data         = d;
        udp_send_data_ready = rdy;
        udp_rec_data_valid  = rv;
        udp_rec_rdata       = rb;
        model_step(wr, d, rdy, rv, rb);
        @(posedge clk);
        #1;
        compare_outputs();
        @(negedge clk);
    endtask

    task automatic do_reset();
        wav_wren           = 1'b0;
        udp_rec_data_valid = 1'b0;
        rst_n              = 1'b0;
        #1;
        model_reset();
        check("rst_valid", 64'(udp_send_data_valid), 64'd0);
        check("rst_data_hi", udp_send_data[PW -: 64], 64'd0);
        check("rst_data_lo", udp_send_data[63:0], 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic strobes(input int n, input logic [15:0] base, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b1, base + 16'(i), rdy, 1'b0, 8'h00);
    endtask

    int rec_left;
    bit rec_first;
    logic [7:0] cmd;

    initial begin
        m_pkts = 0;
        model_reset();
        @(negedge clk);
        do_reset();
        check("length", 64'(udp_send_data_length), 64'd120);

        // Single packet, samples 1..60, ready high.
        strobes(N, 16'h0001, 1'b1);
        check("p1_first", 64'(udp_send_data[959:944]), 64'h0001);
        check("p1_last", 64'(udp_send_data[15:0]), 64'h003C);
        check("p1_seq", 64'(udp_send_data[960]), 64'd1);
        check("p1_vld", 64'(udp_send_data_valid), 64'd1);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 8'h00);
        check("p1_vld_clr", 64'(udp_send_data_valid), 64'd0);

        // Two packets back to back.
        do_reset();
        strobes(N, 16'h0010, 1'b1);
        check("two_seq_a", 64'(udp_send_data[960]), 64'd1);
        strobes(N, 16'h0100, 1'b1);
        check("two_seq_b", 64'(udp_send_data[960]), 64'd0);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 8'h00);

        // Ready low: second packet dropped, first held.
        do_reset();
        strobes(2 * N, 16'h0400, 1'b0);
        check("hold_vld", 64'(udp_send_data_valid), 64'd1);
        check("hold_first", 64'(udp_send_data[959:944]), 64'h0400);
        check("hold_seq", 64'(udp_send_data[960]), 64'd1);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 8'h00);
        check("hold_clr", 64'(udp_send_data_valid), 64'd0);

        // Disable via command, then re-enable.
        do_reset();
        cyc(1'b0, 16'h0, 1'b1, 1'b1, 8'h00);
        cyc(1'b0, 16'h0, 1'b1, 1'b1, 8'h01);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 8'h00);
        strobes(N, 16'h0800, 1'b1);
        check("off_vld", 64'(udp_send_data_valid), 64'd0);
        cyc(1'b0, 16'h0, 1'b1, 1'b1, 8'h01);
        cyc(1'b0, 16'h0, 1'b1, 1'b1, 8'h00);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 8'h00);
        strobes(N, 16'h0900, 1'b1);
        check("on_vld", 64'(udp_send_data_valid), 64'd1);
        check("on_first", 64'(udp_send_data[959:944]), 64'h0900);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 8'h00);

        // Reset mid-packet discards the partial packet.
        do_reset();
        strobes(30, 16'h0A00, 1'b1);
        do_reset();
        strobes(N, 16'h0B00, 1'b1);
        check("mid_rst_first", 64'(udp_send_data[959:944]), 64'h0B00);
        check("mid_rst_last", 64'(udp_send_data[15:0]), 64'h0B3B);
        check("mid_rst_seq", 64'(udp_send_data[960]), 64'd1);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 8'h00);

        // Completion coincides with acceptance of the previous packet.
        do_reset();
        strobes(N, 16'h0C00, 1'b0);
        strobes(N - 1, 16'h0D00, 1'b0);
        cyc(1'b1, 16'h0D3B, 1'b1, 1'b0, 8'h00);
        check("same_vld", 64'(udp_send_data_valid), 64'd1);
        check("same_first", 64'(udp_send_data[959:944]), 64'h0D00);
        check("same_seq", 64'(udp_send_data[960]), 64'd0);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 8'h00);

        // Randomized traffic with command packets and occasional resets.
        do_reset();
        rec_left  = 0;
        rec_first = 1'b0;
        cmd       = 8'h01;
        for (int i = 0; i < 6000; i++) begin
            bit          rv;
            logic [7:0]  rb;
            int          r;
            if (i % 997 == 996) do_reset();
            rv = 1'b0;
            rb = 8'($urandom);
            if (rec_left > 0) begin
                rv = 1'b1;
                if (rec_first) rb = cmd;
                rec_first = 1'b0;
                rec_left--;
            end else if ($urandom_range(0, 59) == 0) begin
                rec_left  = $urandom_range(1, 4);
                rec_first = 1'b1;
                r = $urandom_range(0, 9);
                cmd = (r < 3) ? 8'h00 : (r < 8) ? 8'h01 : 8'h5A;
            end
            cyc($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 3) != 0, rv, rb);
        end
        check("rand_pkts_seen", 64'(m_pkts > 20), 64'd1);
        check("length_end", 64'(udp_send_data_length), 64'd120);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
